// File: rtl/pgm_fifo_rd_stream_v1_0.sv
// Read-side streaming engine: issues reads to the FIFO controller, captures RAM data after a
// fixed latency into a small prefetch buffer, and presents it as a valid/ready stream.
//   state    | meaning
//   ST_RUN   | issuing reads, capturing returns, streaming the buffer head
//   ST_FLUSH | buffer cleared; returning in-flight words are dropped until the valid pipe drains
module pgm_fifo_rd_stream_v1_0 #(
    parameter int c_DATA_WIDTH = 8,
    parameter int c_LAST_BIT   = 7,
    parameter int c_RD_LATENCY = 1,
    parameter int c_PF_DEPTH   = 4
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rempty,
    output logic                    r_en,
    input  logic [c_DATA_WIDTH-1:0] rdata,
    input  logic                    flush,
    output logic [c_DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [15:0]             frame_cnt,
    output logic                    busy
);

    localparam int PTR_W = $clog2(c_PF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [c_RD_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [CNT_W-1:0]        occ_q, occ_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [c_DATA_WIDTH-1:0] mem_q [c_PF_DEPTH];

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W:0]          committed;
    logic                    room;
    logic                    vpipe_out;
    logic                    wr_en;
    logic                    hs;
    logic [c_DATA_WIDTH-1:0] head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < c_RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vpipe_q[i]);
        end
    end

    // Issue gating keeps occ + inflight within the buffer, so the pointers can never overrun.
    assign committed = {1'b0, occ_q} + {1'b0, inflight};
    assign room      = committed < (CNT_W + 1)'(c_PF_DEPTH);
    assign r_en      = !rrst && (state_q == ST_RUN) && !flush && !rempty && room;

    assign vpipe_out = vpipe_q[c_RD_LATENCY-1];
    assign head      = mem_q[rd_ptr_q];
    assign m_tvalid  = (occ_q != '0) && (state_q == ST_RUN);
    assign m_tdata   = m_tvalid ? head : '0;
    assign m_tlast   = m_tdata[c_LAST_BIT];
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q == ST_FLUSH);

    always_comb begin
        vpipe_d[0] = r_en;
        for (int i = 1; i < c_RD_LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;
        hs          = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    // Flush wins over a coincident capture or handshake.
                    state_d  = ST_FLUSH;
                    occ_d    = '0;
                    rd_ptr_d = wr_ptr_q;
                end else begin
                    wr_en = vpipe_out;
                    hs    = m_tvalid && m_tready;
                    if (wr_en) begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                    if (hs) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        if (m_tlast) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                    end
                    occ_d = occ_q + CNT_W'(wr_en) - CNT_W'(hs);
                end
            end
            ST_FLUSH: begin
                if (vpipe_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= ST_RUN;
            vpipe_q     <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vpipe_q     <= vpipe_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst && wr_en) begin
            mem_q[wr_ptr_q] <= rdata;
        end
    end

endmodule

// File: tb/tb_pgm_fifo_rd_stream_v1_0.sv
// Directed bench for the read stream engine at latency 2, depth 4, with an upstream
// FIFO/RAM model that returns popped words two cycles after the read is issued.
module tb_pgm_fifo_rd_stream_v1_0;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic        r_en;
    logic [7:0]  rdata;
    logic        flush;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] frame_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] fmem [256];
    logic [7:0] head_q = 8'd0;
    logic [7:0] tail   = 8'd0;
    logic [7:0] s1     = 8'hEE;

    always #5 rclk = ~rclk;

    pgm_fifo_rd_stream_v1_0 #(
        .c_DATA_WIDTH(8),
        .c_LAST_BIT  (7),
        .c_RD_LATENCY(2),
        .c_PF_DEPTH  (4)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rempty   (rempty),
        .r_en     (r_en),
        .rdata    (rdata),
        .flush    (flush),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .frame_cnt(frame_cnt),
        .busy     (busy)
    );

    // Upstream model: pop on r_en, data appears on rdata two edges later; junk otherwise.
    assign rempty = (head_q == tail);
    always @(posedge rclk) begin
        if (r_en) begin
            s1     <= fmem[head_q];
            head_q <= head_q + 8'd1;
        end else begin
            s1 <= 8'hEE;
        end
        rdata <= s1;
    end

    task automatic step();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic push(input logic [7:0] d);
        fmem[tail] = d;
        tail = tail + 8'd1;
    endtask

    task automatic test_reset();
        rrst = 1'b1; flush = 1'b0; m_tready = 1'b0;
        step(); step();
        push(8'h85);
        #1;
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got %b exp 0", r_en); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid); end
        checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h exp 00", m_tdata); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", m_tlast); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt got %h exp 0000", frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        logic [4:0] er;
        logic [4:0] ev;
        er = 5'b00001;
        ev = 5'b01000;
        m_tready = 1'b1;
        rrst = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (r_en !== er[c]) begin errors++; $display("FAIL single_r_en c%0d got %b exp %b", c, r_en, er[c]); end
            checks++; if (m_tvalid !== ev[c]) begin errors++; $display("FAIL single_tvalid c%0d got %b exp %b", c, m_tvalid, ev[c]); end
            if (ev[c]) begin
                checks++; if (m_tdata !== 8'h85) begin errors++; $display("FAIL single_tdata got %h exp 85", m_tdata); end
                checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL single_tlast got %b exp 1", m_tlast); end
            end
            step();
        end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_burst();
        logic er, ev;
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        #1;
        for (int c = 0; c < 20; c++) begin
            er = (c < 16);
            ev = (c >= 3) && (c < 19);
            checks++; if (r_en !== er) begin errors++; $display("FAIL burst_r_en c%0d got %b exp %b", c, r_en, er); end
            checks++; if (m_tvalid !== ev) begin errors++; $display("FAIL burst_tvalid c%0d got %b exp %b", c, m_tvalid, ev); end
            if (ev) begin
                checks++; if (m_tdata !== 8'(c - 3)) begin errors++; $display("FAIL burst_tdata c%0d got %h exp %h", c, m_tdata, 8'(c - 3)); end
            end
            step();
        end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL burst_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_backpressure();
        int nren;
        int idx;
        logic [7:0] exp_d;
        m_tready = 1'b0;
        for (int i = 0; i < 9; i++) push(8'h20 + 8'(i));
        push(8'hA9);
        #1;
        nren = 0;
        for (int c = 0; c < 10; c++) begin
            if (r_en) nren++;
            if (c >= 4) begin
                checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h20) begin
                    errors++; $display("FAIL bp_stall c%0d got v=%b d=%h exp v=1 d=20", c, m_tvalid, m_tdata);
                end
            end
            step();
        end
        checks++; if (nren != 4) begin errors++; $display("FAIL bp_issue_count got %0d exp 4", nren); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL bp_r_en_held got %b exp 0", r_en); end
        m_tready = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            if (m_tvalid) begin
                exp_d = (idx < 9) ? (8'h20 + 8'(idx)) : 8'hA9;
                checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL bp_data idx%0d got %h exp %h", idx, m_tdata, exp_d); end
                idx++;
            end
            step();
        end
        checks++; if (idx != 10) begin errors++; $display("FAIL bp_delivered got %0d exp 10", idx); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_frame_cnt got %0d exp 2", frame_cnt); end
    endtask

    task automatic test_flush();
        int n;
        int idx;
        m_tready = 1'b0;
        push(8'hC0);
        for (int i = 1; i < 10; i++) push(8'h40 + 8'(i));
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL flush_fill_r_en c%0d got %b exp 1", c, r_en); end
            step();
        end
        checks++; if (r_en !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 8'hC0) begin
            errors++; $display("FAIL flush_pre got r_en=%b v=%b d=%h exp r_en=0 v=1 d=c0", r_en, m_tvalid, m_tdata);
        end
        flush = 1'b1;
        m_tready = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (busy !== 1'b1 || m_tvalid !== 1'b0 || r_en !== 1'b0) begin
                errors++; $display("FAIL flush_busy c%0d got busy=%b v=%b r_en=%b exp 1 0 0", c, busy, m_tvalid, r_en);
            end
            step();
        end
        checks++; if (busy !== 1'b0 || r_en !== 1'b1) begin
            errors++; $display("FAIL flush_resume got busy=%b r_en=%b exp 0 1", busy, r_en);
        end
        n = 0;
        while (!m_tvalid && n < 10) begin
            step();
            n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL flush_first_latency got %0d exp 3", n); end
        idx = 0;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            if (m_tvalid) begin
                checks++; if (m_tdata !== 8'h44 + 8'(idx)) begin
                    errors++; $display("FAIL flush_data idx%0d got %h exp %h", idx, m_tdata, 8'h44 + 8'(idx));
                end
                idx++;
            end
            step();
        end
        checks++; if (idx != 6) begin errors++; $display("FAIL flush_delivered got %0d exp 6", idx); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL flush_frame_cnt got %0d exp 2", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
        for (int c = 0; c < 5; c++) step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hE0) begin
            errors++; $display("FAIL rmid_pre got v=%b d=%h exp v=1 d=e0", m_tvalid, m_tdata);
        end
        rrst = 1'b1;
        step();
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0) begin
            errors++; $display("FAIL rmid_stream got v=%b d=%h l=%b exp 0 00 0", m_tvalid, m_tdata, m_tlast);
        end
        checks++; if (frame_cnt !== 16'h0 || busy !== 1'b0 || r_en !== 1'b0) begin
            errors++; $display("FAIL rmid_ctrl got fc=%h busy=%b r_en=%b exp 0000 0 0", frame_cnt, busy, r_en);
        end
        rrst = 1'b0;
        m_tready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_late_capture c%0d got %b exp 0", c, m_tvalid); end
            step();
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int got;
        int n;
        logic [7:0] diff;
        m_tready = 1'b1;
        pushed = 0;
        got = 0;
        for (int c = 0; c < 70000 && got < 65535; c++) begin
            diff = tail - head_q;
            if (pushed < 65535 && diff < 8'd64) begin
                push(8'h80);
                pushed++;
            end
            if (m_tvalid) got++;
            step();
        end
        checks++; if (got != 65535) begin errors++; $display("FAIL wrap_frames got %0d exp 65535", got); end
        checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffff", frame_cnt); end
        push(8'h81);
        n = 0;
        while (!m_tvalid && n < 10) begin
            step();
            n++;
        end
        checks++; if (!m_tvalid) begin errors++; $display("FAIL wrap_last_timeout got v=%b exp 1", m_tvalid); end
        step();
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_rollover got %h exp 0000", frame_cnt); end
    endtask

    initial begin
        rrst = 1'b1;
        flush = 1'b0;
        m_tready = 1'b0;
        @(negedge rclk);
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
